// File: rtl/mmix_bus_pkg.sv
// Shared Avalon-MM bus widths and types for the MMIX 64-bit data master.
// Used by the memory responder and the core-side bus adapter.
package mmix_bus_pkg;

   localparam int AVM_ADDR_W = 28;
   localparam int AVM_DATA_W = 64;
   localparam int AVM_BE_W   = 8;

   typedef logic [AVM_ADDR_W-1:0] avm_addr_t;
   typedef logic [AVM_DATA_W-1:0] avm_data_t;
   typedef logic [AVM_BE_W-1:0]   avm_be_t;

endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM bus bundle between the 64-bit data master and the memory responder.
interface avalon_mem_responder_if;
   import mmix_bus_pkg::*;

   avm_addr_t s_address;
   avm_be_t   s_byteenable;
   logic      s_read;
   logic      s_write;
   avm_data_t s_writedata;
   logic      s_waitrequest;
   avm_data_t s_readdata;
   logic      s_readdatavalid;

   modport master (
      output s_address, s_byteenable, s_read, s_write, s_writedata,
      input  s_waitrequest, s_readdata, s_readdatavalid
   );

   modport slave (
      input  s_address, s_byteenable, s_read, s_write, s_writedata,
      output s_waitrequest, s_readdata, s_readdatavalid
   );

endinterface

// File: rtl/avm_read_pipe.sv
// Fixed-latency read response pipe: carries valid + captured read word through
// READ_LATENCY stages and tracks how many reads are still in flight.
module avm_read_pipe
   import mmix_bus_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int MAX_PEND     = 4
) (
   input  logic      clk,
   input  logic      reset_n,
   input  logic      push,
   input  avm_data_t push_data,
   output logic      rd_valid,
   output avm_data_t rd_data,
   output logic      full
);

   localparam int PEND_W = $clog2(MAX_PEND + 1);

   logic [READ_LATENCY-1:0] valid_q, valid_d;
   avm_data_t               data_q [READ_LATENCY];
   avm_data_t               data_d [READ_LATENCY];
   logic [PEND_W-1:0]       pend_q, pend_d;

   always_comb begin
      valid_d[0] = push;
      data_d[0]  = push ? push_data : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = data_q[i-1];
      end
      // A response leaving while a new read enters leaves the count unchanged
      pend_d = pend_q;
      case ({push, rd_valid})
         2'b10:   pend_d = pend_q + PEND_W'(1);
         2'b01:   pend_d = pend_q - PEND_W'(1);
         default: pend_d = pend_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         pend_q  <= '0;
         for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         pend_q  <= pend_d;
         for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= data_d[i];
      end
   end

   assign rd_valid = valid_q[READ_LATENCY-1];
   assign rd_data  = data_q[READ_LATENCY-1];
   assign full     = (pend_q == PEND_W'(MAX_PEND));

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM responder backed by an octa-wide on-chip RAM with byte-lane writes.
// Define AVM_WAIT_INJECT_EN to add LFSR-driven pseudo-random waitrequest stalls.
module avalon_mem_responder
   import mmix_bus_pkg::*;
#(
   parameter int DEPTH_LOG2   = 12,
   parameter int READ_LATENCY = 2,
   parameter int MAX_PEND     = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   avalon_mem_responder_if.slave  bus,
   output logic                   protocol_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   avm_data_t             mem [DEPTH];
   avm_addr_t             addr;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  unused_addr;
   logic                  inject;
   logic                  pipe_full;
   logic                  wait_req;
   logic                  wr_accept;
   logic                  rd_accept;
   logic                  rd_valid;
   avm_data_t             rd_data;
   logic                  protocol_err_q, protocol_err_d;

   // Byte offset and bits above the RAM depth are don't-care, so addresses alias
   assign addr        = bus.s_address;
   assign idx         = addr[DEPTH_LOG2+2:3];
   assign unused_addr = ^addr;

`ifdef AVM_WAIT_INJECT_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr_q <= 16'hACE1;
      else          lfsr_q <= lfsr_d;
   end

   assign inject = (lfsr_q[1:0] == 2'b00) & (bus.s_read | bus.s_write);
`else
   assign inject = 1'b0;
`endif

   assign wait_req  = (bus.s_read & pipe_full) | inject;
   assign wr_accept = bus.s_write & ~wait_req;
   assign rd_accept = bus.s_read & ~bus.s_write & ~wait_req;

   always_ff @(posedge clk) begin
      for (int i = 0; i < AVM_BE_W; i++) begin
         if (wr_accept && bus.s_byteenable[i])
            mem[idx][8*i +: 8] <= bus.s_writedata[8*i +: 8];
      end
   end

   avm_read_pipe #(
      .READ_LATENCY (READ_LATENCY),
      .MAX_PEND     (MAX_PEND)
   ) u_read_pipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (rd_accept),
      .push_data (mem[idx]),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .full      (pipe_full)
   );

   always_comb begin
      protocol_err_d = protocol_err_q | (bus.s_read & bus.s_write);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) protocol_err_q <= 1'b0;
      else          protocol_err_q <= protocol_err_d;
   end

   assign bus.s_waitrequest   = wait_req;
   assign bus.s_readdata      = rd_data;
   assign bus.s_readdatavalid = rd_valid;
   assign protocol_err        = protocol_err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed self-checking bench for avalon_mem_responder: one default instance
// (latency 2, 4 pending) and one small instance (latency 3, 1 pending).
module tb_avalon_mem_responder;
   import mmix_bus_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic err_a, err_b;
   int   cyc = 0;
   int   check_count = 0;
   int   error_count = 0;

   avm_data_t resp_a[$];
   int        resp_cyc_a[$];
   avm_data_t resp_b[$];
   int        resp_cyc_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avalon_mem_responder_if bus_a();
   avalon_mem_responder_if bus_b();

   avalon_mem_responder #(.DEPTH_LOG2(12), .READ_LATENCY(2), .MAX_PEND(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a), .protocol_err(err_a));

   avalon_mem_responder #(.DEPTH_LOG2(4), .READ_LATENCY(3), .MAX_PEND(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b), .protocol_err(err_b));

   // Response monitors record each valid pulse with the cycle it was seen in
   always @(negedge clk) begin
      if (bus_a.s_readdatavalid) begin
         resp_a.push_back(bus_a.s_readdata);
         resp_cyc_a.push_back(cyc);
      end
      if (bus_b.s_readdatavalid) begin
         resp_b.push_back(bus_b.s_readdata);
         resp_cyc_b.push_back(cyc);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic driveBus(input bit sel_b, input bit rd, input bit wr, input avm_addr_t addr,
                           input avm_data_t data, input avm_be_t be);
      if (sel_b) begin
         bus_b.s_read = rd; bus_b.s_write = wr; bus_b.s_address = addr;
         bus_b.s_writedata = data; bus_b.s_byteenable = be;
      end else begin
         bus_a.s_read = rd; bus_a.s_write = wr; bus_a.s_address = addr;
         bus_a.s_writedata = data; bus_a.s_byteenable = be;
      end
   endtask

   // Called at a falling edge; holds the request until accepted, returns at the
   // falling edge after the accepting rising edge with the request removed.
   task automatic applyStimulus(input bit sel_b, input bit rd, input bit wr,
                                input avm_addr_t addr, input avm_data_t data,
                                input avm_be_t be, output int accept_cyc, output int waits);
      bit   done;
      logic wreq;
      done  = 1'b0;
      waits = 0;
      driveBus(sel_b, rd, wr, addr, data, be);
      while (!done) begin
         #1;
         wreq = sel_b ? bus_b.s_waitrequest : bus_a.s_waitrequest;
         @(posedge clk);
         @(negedge clk);
         if (!wreq) done = 1'b1;
         else begin
            waits++;
            if (waits >= 40) begin
               checkOutput("accept_timeout", 64'(waits), 64'd0);
               done = 1'b1;
            end
         end
      end
      accept_cyc = cyc;
      driveBus(sel_b, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic doRead(input avm_addr_t addr, output avm_data_t data, output int latency);
      int acc, w;
      applyStimulus(1'b0, 1'b1, 1'b0, addr, '0, '0, acc, w);
      for (int k = 0; k < 20 && resp_a.size() == 0; k++) begin
         @(negedge clk); #1;
      end
      if (resp_a.size() == 0) begin
         checkOutput("read_timeout", 64'd0, 64'd1);
         data    = '0;
         latency = -1;
      end else begin
         data    = resp_a.pop_front();
         latency = resp_cyc_a.pop_front() - acc + 1;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk); #1;
      end
   endtask

   initial begin
      avm_data_t rdata;
      int        lat, acc, w;
      int        acc4[4];
      int        waits4;
      int        acc_b1, acc_b2, w_b1, w_b2;

      driveBus(1'b0, 1'b0, 1'b0, '0, '0, '0);
      driveBus(1'b1, 1'b0, 1'b0, '0, '0, '0);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_readdatavalid", 64'(bus_a.s_readdatavalid), 64'd0);
      checkOutput("rst_readdata", bus_a.s_readdata, 64'd0);
      checkOutput("rst_protocol_err", 64'(err_a), 64'd0);
      checkOutput("rst_waitrequest", 64'(bus_a.s_waitrequest), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Full write then read back with latency measurement
      applyStimulus(1'b0, 1'b0, 1'b1, 28'h100, 64'h0123456789ABCDEF, 8'hFF, acc, w);
      doRead(28'h100, rdata, lat);
      checkOutput("t1_data", rdata, 64'h0123456789ABCDEF);
      checkOutput("t1_latency", 64'(lat), 64'd2);

      // Single-lane write touches only byte 4
      applyStimulus(1'b0, 1'b0, 1'b1, 28'h100, 64'hFFFFFFFFFFFFFFFF, 8'h10, acc, w);
      doRead(28'h100, rdata, lat);
      checkOutput("t2_lane4", rdata, 64'h012345FF89ABCDEF);
      applyStimulus(1'b0, 1'b0, 1'b1, 28'h100, 64'h0, 8'h00, acc, w);
      doRead(28'h100, rdata, lat);
      checkOutput("t2_be_zero", rdata, 64'h012345FF89ABCDEF);
      doRead(28'h8104, rdata, lat);
      checkOutput("t2_alias", rdata, 64'h012345FF89ABCDEF);

      // Back-to-back reads stream out in order, one per cycle
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b0, 1'b1, avm_addr_t'(8 * i), avm_data_t'(i + 1), 8'hFF, acc, w);
      idleCycles(3);
      resp_a.delete(); resp_cyc_a.delete();
      waits4 = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, avm_addr_t'(8 * i), '0, '0, acc4[i], w);
         waits4 += w;
      end
      idleCycles(6);
      checkOutput("t3_count", 64'(resp_a.size()), 64'd4);
      checkOutput("t3_waits", 64'(waits4), 64'd0);
      for (int i = 0; i < 4 && i < resp_a.size(); i++) begin
         checkOutput($sformatf("t3_data%0d", i), resp_a[i], avm_data_t'(i + 1));
         checkOutput($sformatf("t3_cycle%0d", i), 64'(resp_cyc_a[i] - acc4[0]), 64'(i + 1));
      end
      resp_a.delete(); resp_cyc_a.delete();

      // Single-outstanding instance: second read stalls until first response
      applyStimulus(1'b1, 1'b0, 1'b1, 28'h10, 64'hAAAA, 8'hFF, acc, w);
      applyStimulus(1'b1, 1'b0, 1'b1, 28'h18, 64'hBBBB, 8'hFF, acc, w);
      resp_b.delete(); resp_cyc_b.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 28'h10, '0, '0, acc_b1, w_b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 28'h18, '0, '0, acc_b2, w_b2);
      idleCycles(6);
      checkOutput("t4_first_waits", 64'(w_b1), 64'd0);
      checkOutput("t4_second_waits", 64'(w_b2), 64'd3);
      checkOutput("t4_accept_gap", 64'(acc_b2 - acc_b1), 64'd4);
      checkOutput("t4_count", 64'(resp_b.size()), 64'd2);
      if (resp_b.size() == 2) begin
         checkOutput("t4_data0", resp_b[0], 64'hAAAA);
         checkOutput("t4_data1", resp_b[1], 64'hBBBB);
         checkOutput("t4_latency", 64'(resp_cyc_b[0] - acc_b1 + 1), 64'd3);
      end

      // Reset while a read is in flight drops its response, keeps RAM
      applyStimulus(1'b0, 1'b0, 1'b1, 28'h40, 64'hDEADBEEF00001234, 8'hFF, acc, w);
      resp_a.delete(); resp_cyc_a.delete();
      applyStimulus(1'b0, 1'b1, 1'b0, 28'h40, '0, '0, acc, w);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      idleCycles(5);
      checkOutput("t5_no_response", 64'(resp_a.size()), 64'd0);
      checkOutput("t5_protocol_err", 64'(err_a), 64'd0);
      doRead(28'h40, rdata, lat);
      checkOutput("t5_ram_kept", rdata, 64'hDEADBEEF00001234);

      // Simultaneous read and write: write lands, read dropped, error sticks
      resp_a.delete(); resp_cyc_a.delete();
      applyStimulus(1'b0, 1'b1, 1'b1, 28'h20, 64'h5555555555555555, 8'hFF, acc, w);
      idleCycles(6);
      checkOutput("t6_no_response", 64'(resp_a.size()), 64'd0);
      checkOutput("t6_protocol_err", 64'(err_a), 64'd1);
      doRead(28'h20, rdata, lat);
      checkOutput("t6_written", rdata, 64'h5555555555555555);
      idleCycles(2);
      checkOutput("t6_err_sticky", 64'(err_a), 64'd1);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
